// File: rtl/mii_phy_decoder.sv
// MII receive decoder: syncs the PHY nibble stream, strips preamble/SFD, checks length and CRC,
// buffers one frame and replays good frames as a valid/ready byte stream. Option: MII_DECODER_KEEP_FCS_EN.
//
// state   | meaning
// IDLE    | waiting for a frame start (only after dv has been seen low)
// PRE     | inside preamble, waiting for SFD nibble 0xD
// DATA    | assembling bytes into the buffer, running CRC
// DROP    | frame rejected during receive, waiting for dv=0
// CHECK   | one-cycle verdict on length, alignment, rx_er and CRC residue
// OUT     | replaying the buffered frame downstream
module mii_phy_decoder #(
  parameter int MTU            = 1518,
  parameter int MIN_FRAME_SIZE = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        enet_rx_clk,
  input  logic        enet_rx_dv,
  input  logic        enet_rx_er,
  input  logic [3:0]  enet_rx_data,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_last,
  input  logic        rx_ready,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_bad_cnt
);

  localparam int LW = ($clog2(MTU + 1) < 11) ? 11 : $clog2(MTU + 1);
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DROP  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  logic [2:0]    clk_s;
  logic [1:0]    dv_s;
  logic [1:0]    er_s;
  logic [3:0]    data_s1;
  logic [3:0]    data_s2;

  logic          tick;
  logic          dv;
  logic          er;
  logic [3:0]    nib;

  logic [2:0]    state;
  logic [LW-1:0] len;
  logic [LW-1:0] idx;
  logic [LW-1:0] idx_nxt;
  logic [LW-1:0] last_idx;
  logic [31:0]   crc;
  logic [3:0]    lo_nib;
  logic          hi_phase;
  logic          er_seen;
  logic          armed;

  logic [7:0]    buffer [0:MTU-1];
  logic          wr_en;
  logic [7:0]    wr_data;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      clk_s   <= '0;
      dv_s    <= '0;
      er_s    <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      clk_s   <= {clk_s[1:0], enet_rx_clk};
      dv_s    <= {dv_s[0], enet_rx_dv};
      er_s    <= {er_s[0], enet_rx_er};
      data_s1 <= enet_rx_data;
      data_s2 <= data_s1;
    end
  end

  assign tick = clk_s[1] & ~clk_s[2];
  assign dv   = dv_s[1];
  assign er   = er_s[1];
  assign nib  = data_s2;

`ifdef MII_DECODER_KEEP_FCS_EN
  assign last_idx = len - LW'(1);
`else
  assign last_idx = len - LW'(5);
`endif

  assign idx_nxt = idx + LW'(1);
  assign wr_data = {nib, lo_nib};
  assign wr_en   = tick && (state == S_DATA) && dv && hi_phase && (len != LW'(MTU));

  always_ff @(posedge i_clk) begin
    if (wr_en) buffer[len] <= wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      len           <= '0;
      idx           <= '0;
      crc           <= '1;
      lo_nib        <= '0;
      hi_phase      <= 1'b0;
      er_seen       <= 1'b0;
      armed         <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_last       <= 1'b0;
      frame_ok_cnt  <= '0;
      frame_bad_cnt <= '0;
    end else begin
      // A frame may only start after dv has been observed low, so partial frames are never picked up
      if (tick && !dv) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          if (tick && dv && armed) begin
            if (nib == 4'h5) begin
              state <= S_PRE;
            end else begin
              state         <= S_DROP;
              frame_bad_cnt <= frame_bad_cnt + 16'd1;
            end
          end
        end
        S_PRE: begin
          if (tick) begin
            if (!dv) begin
              state <= S_IDLE;
            end else if (nib == 4'hD) begin
              state    <= S_DATA;
              len      <= '0;
              crc      <= '1;
              hi_phase <= 1'b0;
              er_seen  <= 1'b0;
            end else if (nib != 4'h5) begin
              state         <= S_DROP;
              frame_bad_cnt <= frame_bad_cnt + 16'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (!dv) begin
              state <= S_CHECK;
            end else begin
              if (er) er_seen <= 1'b1;
              if (!hi_phase) begin
                lo_nib   <= nib;
                hi_phase <= 1'b1;
              end else if (len == LW'(MTU)) begin
                state         <= S_DROP;
                frame_bad_cnt <= frame_bad_cnt + 16'd1;
              end else begin
                len      <= len + LW'(1);
                crc      <= crc_byte(crc, wr_data);
                hi_phase <= 1'b0;
              end
            end
          end
        end
        S_DROP: begin
          if (tick && !dv) state <= S_IDLE;
        end
        S_CHECK: begin
          if (hi_phase || (len < LW'(MIN_FRAME_SIZE)) || er_seen || (crc != CRC_RESIDUE)) begin
            state         <= S_IDLE;
            frame_bad_cnt <= frame_bad_cnt + 16'd1;
          end else begin
            state        <= S_OUT;
            frame_ok_cnt <= frame_ok_cnt + 16'd1;
            idx          <= '0;
            rx_valid     <= 1'b1;
            rx_data      <= buffer[0];
            rx_last      <= (last_idx == '0);
          end
        end
        S_OUT: begin
          // A frame arriving during replay is counted once and then ignored until dv drops
          if (tick && dv && armed) begin
            armed         <= 1'b0;
            frame_bad_cnt <= frame_bad_cnt + 16'd1;
          end
          if (rx_ready) begin
            if (rx_last) begin
              state    <= S_IDLE;
              rx_valid <= 1'b0;
              rx_last  <= 1'b0;
            end else begin
              idx     <= idx_nxt;
              rx_data <= buffer[idx_nxt];
              rx_last <= (idx_nxt == last_idx);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
